// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, timeout counter sizing
// and the registered response bundle.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_DATA_W         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  // Counter only has to represent 0 .. TIMEOUT_CYCLES-1.
  function automatic int tcnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int TCNT_W = tcnt_width(TIMEOUT_CYCLES_DEF);

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: cleared before ACCESS starts, counts stalled
// cycles and flags the last permitted one.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = tcnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Saturates at LAST so a late enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns single-beat core requests into SETUP/ACCESS transfers
// and returns the slave's reply on a valid/ready response channel.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  apb_state_e            state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_rsp_t              rsp_q,       rsp_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;

  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expired_o(tmo_expired)
  );

  // Every output is a flop, so this block computes the value each output
  // must show in the state being entered, not the current one.
  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    tmo_clear   = 1'b0;
    tmo_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = SETUP;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          paddr_d     = req_addr;
          pwrite_d    = req_write;
          pwdata_d    = req_write ? req_wdata : '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        tmo_clear = 1'b1;
      end

      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        // PREADY is checked first so a reply in the final allowed cycle wins.
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
          rsp_d.err     = PSLVERR;
          rsp_d.timeout = 1'b0;
        end else if (tmo_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
        end else begin
          tmo_enable = 1'b1;
        end
      end

      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Asynchronous reset drops PSEL/PENABLE at once, abandoning any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB3 requester that turns single-beat bus requests from the core-side load/store path into APB SETUP/ACCESS transfers toward peripheral slaves such as the UART. It owns the initiating end of the APB interface: it drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, waits for PREADY, and returns PRDATA/PSLVERR on a valid/ready response channel. A wait-state timeout keeps the core from locking up on a slave that never asserts PREADY.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 256, max ACCESS cycles without PREADY before abort (≥2)
- clk  in  1  system clock, also drives PCLK domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request this cycle
- req_addr  in  ADDR_WIDTH  transfer address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  core consumes response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1; on req_valid&req_ready capture addr/write/wdata -> SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from captured request -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/control/data held stable. On PREADY=1: capture PRDATA (reads only, writes return 0), rsp_err=PSLVERR, rsp_timeout=0 -> RESP.
- Timeout: wait counter cleared on entry to ACCESS, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES-1 with PREADY still 0 -> RESP with rsp_rdata=0, rsp_err=1, rsp_timeout=1. PREADY=1 in the terminal cycle wins over timeout.
- RESP: PSEL=PENABLE=0; rsp_valid=1, rsp_* held stable until rsp_ready=1 -> IDLE, rsp_valid drops next cycle.
- req_ready=0 in SETUP/ACCESS/RESP; requests there are not accepted and must be held by the core.
- PWDATA driven 0 for reads; PADDR/PWRITE keep last value in IDLE/RESP.
- Reset mid-transfer: immediate abort, no response generated; slave sees PSEL fall asynchronously.

## Timing
- All outputs registered. Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; state=IDLE.
- req_ready rises the first clk edge after rst deasserts.
- Zero-wait slave: accept at edge N, SETUP N+1, ACCESS N+2 (PREADY=1), rsp_valid N+3; with rsp_ready=1, req_ready again at N+4. Throughput 1 transfer per 4 cycles minimum.
- Each slave wait state adds 1 cycle. Timeout response appears TIMEOUT_CYCLES cycles after ACCESS entry.
- PENABLE never asserted without PSEL; PSEL never drops between SETUP and ACCESS of the same transfer.

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), TIMEOUT counter width localparam ($clog2(TIMEOUT_CYCLES)), response struct (rdata, err, timeout).
- One sub-module: apb_timeout_cnt (clear, enable, expired output) instantiated by apb_master_bridge.

## Test plan
- Read, zero-wait slave: addr 0x8, PRDATA=0xA5 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_rdata=0x000000A5, rsp_err=0.
- Write with 3 wait states: addr 0xC, wdata 0x55 -> PADDR/PWDATA stable over 4 ACCESS cycles, rsp_valid 6 cycles after accept, rsp_rdata=0.
- Slave never asserts PREADY, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 in RESP.
- PSLVERR=1 with PREADY and TIMEOUT terminal cycle coincident -> rsp_err=1, rsp_timeout=0.
- rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; new req_valid ignored until IDLE.
- rst asserted during ACCESS -> PSEL/PENABLE=0 immediately, no rsp_valid; after release req_ready=1 one edge later and next read completes normally.
